// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: sub-word load extension, read-modify-write
// sub-word stores against a word-wide single-write-enable memory, sticky fault capture.
module mem_access_unit #(
    parameter int N = 32,
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    input  logic         req_write,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] addr,
    input  logic [M-1:0] wdata,
    output logic [M-1:0] rdata,
    output logic         stall,
    output logic         fault,
    output logic [N-1:0] fault_addr,
    input  logic         fault_clr,
    output logic         mem_we,
    output logic [N-1:0] mem_adr,
    output logic [M-1:0] mem_din,
    input  logic [M-1:0] mem_dout
);

    typedef enum logic [0:0] {IDLE, WRITE} state_t;

    state_t       state, state_next;
    logic [N-1:0] wr_adr, wr_adr_next;
    logic [M-1:0] wr_data, wr_data_next;
    logic [N-1:0] word_idx;
    logic         bad, active, access_bad, access_ok;
    logic [7:0]   lane_b;
    logic [15:0]  lane_h;
    logic [M-1:0] load_val, merged;

    assign word_idx = {2'b00, addr[N-1:2]};

    always_comb begin
        bad = 1'b1;
        case (funct3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = addr[0];
            3'b010:         bad = |addr[1:0];
            default:        bad = 1'b1;
        endcase
    end

    // Gating with rst_n keeps every output quiet while reset is held.
    assign active     = rst_n && (state == IDLE) && req_valid;
    assign access_bad = active && bad;
    assign access_ok  = active && !bad;

    always_comb begin
        lane_b = mem_dout[7:0];
        merged = mem_dout;
        case (addr[1:0])
            2'b00: lane_b = mem_dout[7:0];
            2'b01: lane_b = mem_dout[15:8];
            2'b10: lane_b = mem_dout[23:16];
            default: lane_b = mem_dout[31:24];
        endcase
        lane_h = addr[1] ? mem_dout[31:16] : mem_dout[15:0];
        if (funct3[0]) begin
            if (addr[1]) merged[31:16] = wdata[15:0];
            else         merged[15:0]  = wdata[15:0];
        end else begin
            case (addr[1:0])
                2'b00: merged[7:0]   = wdata[7:0];
                2'b01: merged[15:8]  = wdata[7:0];
                2'b10: merged[23:16] = wdata[7:0];
                default: merged[31:24] = wdata[7:0];
            endcase
        end
    end

    always_comb begin
        load_val = mem_dout;
        case (funct3)
            3'b000: load_val = {{(M-8){lane_b[7]}}, lane_b};
            3'b001: load_val = {{(M-16){lane_h[15]}}, lane_h};
            3'b100: load_val = {{(M-8){1'b0}}, lane_b};
            3'b101: load_val = {{(M-16){1'b0}}, lane_h};
            default: load_val = mem_dout;
        endcase
    end

    always_comb begin
        state_next   = state;
        wr_adr_next  = wr_adr;
        wr_data_next = wr_data;
        mem_we       = 1'b0;
        stall        = 1'b0;
        rdata        = '0;
        mem_adr      = word_idx;
        mem_din      = wdata;
        case (state)
            IDLE: begin
                if (access_ok) begin
                    if (!req_write) begin
                        rdata = load_val;
                    end else if (funct3[1:0] == 2'b10) begin
                        mem_we = 1'b1;
                    end else begin
                        stall        = 1'b1;
                        wr_adr_next  = word_idx;
                        wr_data_next = merged;
                        state_next   = WRITE;
                    end
                end
            end
            WRITE: begin
                mem_we     = rst_n;
                mem_adr    = wr_adr;
                mem_din    = wr_data;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_adr  <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_next;
            wr_adr  <= wr_adr_next;
            wr_data <= wr_data_next;
        end
    end

    // A fault arriving together with fault_clr takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (access_bad) begin
            fault <= 1'b1;
            if (!fault || fault_clr) fault_addr <= addr;
        end else if (fault_clr) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: bench-owned memory, reference memory
// model for expected loads and merged store words.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, fault_clr;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata, fault_addr, mem_adr, mem_din, mem_dout;
    logic        stall, fault, mem_we;

    logic [31:0] mem     [0:15];
    logic [31:0] ref_mem [0:15];

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } wr_t;
    wr_t         wr_q[$];
    logic [31:0] rd_q[$];

    int compared   = 0;
    int mismatched = 0;

    mem_access_unit #(.N(32), .M(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .fault(fault), .fault_addr(fault_addr), .fault_clr(fault_clr),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    assign mem_dout = mem[mem_adr[3:0]];
    always @(posedge clk) if (mem_we) mem[mem_adr[3:0]] <= mem_din;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write monitor: every memory write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (wr_q.size() == 0) begin
                chk("spurious_we", {31'b0, mem_we}, 32'd0);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wr_adr", mem_adr, e.adr);
                chk("wr_din", mem_din, e.data);
            end
        end
    end

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [31:0] a);
        logic [31:0] s;
        s = (f3[0] ? (w >> (16 * a[1])) : (w >> (8 * a[1:0])));
        case (f3)
            3'b000:  return s[7] ? (s | 32'hFFFF_FF00) : (s & 32'h0000_00FF);
            3'b100:  return s & 32'h0000_00FF;
            3'b001:  return s[15] ? (s | 32'hFFFF_0000) : (s & 32'h0000_FFFF);
            3'b101:  return s & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] d);
        logic [31:0] m;
        int unsigned sh;
        sh = f3[0] ? 16 * a[1] : 8 * a[1:0];
        m  = (f3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        return (w & ~m) | ((d << sh) & m);
    endfunction

    task automatic drive(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; wdata = d;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        req_valid = 1'b0; fault_clr = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b0, f3, a, 32'h0);
        rd_q.push_back(exp);
        @(negedge clk);
        chk("ld_rdata", rdata, rd_q.pop_front());
        chk("ld_stall", {31'b0, stall}, 32'd0);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] idx;
        wr_t e;
        idx = a >> 2;
        drive(1'b1, f3, a, d);
        if (f3 == 3'b010) begin
            e.adr = idx; e.data = d;
            wr_q.push_back(e);
            @(negedge clk);
            chk("sw_stall", {31'b0, stall}, 32'd0);
            ref_mem[idx[3:0]] = d;
        end else begin
            e.adr = idx; e.data = ref_merge(ref_mem[idx[3:0]], f3, a, d);
            @(negedge clk);
            chk("rmw_stall1", {31'b0, stall}, 32'd1);
            chk("rmw_we1", {31'b0, mem_we}, 32'd0);
            wr_q.push_back(e);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("rmw_stall2", {31'b0, stall}, 32'd0);
            chk("rmw_rdata2", rdata, 32'd0);
            ref_mem[idx[3:0]] = e.data;
        end
    endtask

    task automatic do_bad(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic clr);
        drive(wr, f3, a, 32'hFFFF_FFFF);
        fault_clr = clr;
        @(negedge clk);
        chk("bad_we", {31'b0, mem_we}, 32'd0);
        chk("bad_stall", {31'b0, stall}, 32'd0);
        chk("bad_rdata", rdata, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 32'h0101_0101 * i + 32'h3C00_0000;
            ref_mem[i] = mem[i];
        end
        mem[2] = 32'h8F7F_80FF; ref_mem[2] = 32'h8F7F_80FF;
        mem[1] = 32'h1122_3344; ref_mem[1] = 32'h1122_3344;

        rst_n = 1'b0; fault_clr = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h08; wdata = '0;
        @(negedge clk);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_faddr", fault_addr, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; req_valid = 1'b0;

        do_load(3'b000, 32'h08, 32'hFFFF_FFFF);
        do_load(3'b100, 32'h09, 32'h0000_0080);
        do_load(3'b001, 32'h0A, 32'hFFFF_8F7F);
        do_load(3'b101, 32'h0A, 32'h0000_8F7F);
        do_load(3'b010, 32'h08, 32'h8F7F_80FF);

        do_store(3'b000, 32'h06, 32'h0000_00AB);
        do_load(3'b010, 32'h04, 32'h11AB_3344);
        do_store(3'b001, 32'h04, 32'h0000_BEEF);
        do_load(3'b010, 32'h04, 32'h11AB_BEEF);

        do_store(3'b010, 32'h08, 32'hDEAD_BEEF);
        do_load(3'b010, 32'h08, 32'hDEAD_BEEF);

        do_bad(1'b0, 3'b010, 32'h05, 1'b0);
        idle_cycle();
        @(negedge clk);
        chk("fault_set", {31'b0, fault}, 32'd1);
        chk("fault_addr1", fault_addr, 32'h05);
        do_bad(1'b1, 3'b001, 32'h03, 1'b0);
        idle_cycle();
        @(negedge clk);
        chk("fault_addr_kept", fault_addr, 32'h05);
        do_bad(1'b0, 3'b011, 32'h00, 1'b0);
        idle_cycle();
        @(negedge clk);
        chk("fault_illegal", {31'b0, fault}, 32'd1);
        chk("fault_addr_kept2", fault_addr, 32'h05);

        do_bad(1'b0, 3'b001, 32'h21, 1'b1);
        idle_cycle();
        @(negedge clk);
        chk("clr_newfault", {31'b0, fault}, 32'd1);
        chk("clr_newaddr", fault_addr, 32'h21);
        @(posedge clk);
        #1;
        fault_clr = 1'b1;
        idle_cycle();
        @(negedge clk);
        chk("clr_fault", {31'b0, fault}, 32'd0);
        chk("clr_faddr", fault_addr, 32'd0);

        for (int n = 0; n < 24; n++) begin
            logic [31:0] a;
            logic [2:0]  f3;
            logic [2:0]  ld_codes [5];
            ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            a = $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) begin
                f3 = ld_codes[$urandom_range(0, 2)];
                if (f3 == 3'b001) a[0] = 1'b0;
                if (f3 == 3'b010) a[1:0] = 2'b00;
                do_store(f3, a, $urandom);
            end else begin
                f3 = ld_codes[$urandom_range(0, 4)];
                if (f3[0]) a[0] = 1'b0;
                if (f3 == 3'b010) a[1:0] = 2'b00;
                do_load(f3, a, ref_load(ref_mem[a[5:2]], f3, a));
            end
        end

        drive(1'b1, 3'b000, 32'h0C, 32'h0000_0055);
        @(negedge clk);
        chk("rst_rmw_stall", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rmw_we", {31'b0, mem_we}, 32'd0);
        chk("rst_rmw_stall0", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; req_valid = 1'b0;
        do_load(3'b010, 32'h0C, ref_mem[3]);
        do_store(3'b000, 32'h0D, 32'h0000_0077);
        do_load(3'b010, 32'h0C, ref_mem[3]);

        idle_cycle();
        idle_cycle();
        chk("wr_q_empty", wr_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
